// File: rtl/mahbe_master_arb_if.sv
// Bus bundle between the TX/RX DMA channels, the arbiter and the system AHB master port.
// The master modport is the arbiter's view; the slave modport is the surrounding environment's view.
interface mahbe_master_arb_if;
  logic        m0_hbusreq;
  logic        m1_hbusreq;
  logic [1:0]  m0_htrans;
  logic [1:0]  m1_htrans;
  logic [29:0] m0_haddr;
  logic [29:0] m1_haddr;
  logic        m0_hwrite;
  logic        m1_hwrite;
  logic [31:0] m0_hwdata;
  logic [31:0] m1_hwdata;
  logic        m0_hgrant;
  logic        m1_hgrant;
  logic        m_hready;
  logic [1:0]  m_hresp;
  logic [31:0] m_hrdata;
  logic        HBUSREQ;
  logic        HGRANT;
  logic [1:0]  HTRANS;
  logic [29:0] HADDR;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic [1:0]  owner;

  modport master (
    input  m0_hbusreq, m1_hbusreq, m0_htrans, m1_htrans, m0_haddr, m1_haddr,
           m0_hwrite, m1_hwrite, m0_hwdata, m1_hwdata, HGRANT, HREADY, HRESP, HRDATA,
    output m0_hgrant, m1_hgrant, m_hready, m_hresp, m_hrdata, HBUSREQ,
           HTRANS, HADDR, HWRITE, HWDATA, owner
  );

  modport slave (
    output m0_hbusreq, m1_hbusreq, m0_htrans, m1_htrans, m0_haddr, m1_haddr,
           m0_hwrite, m1_hwrite, m0_hwdata, m1_hwdata, HGRANT, HREADY, HRESP, HRDATA,
    input  m0_hgrant, m1_hgrant, m_hready, m_hresp, m_hrdata, HBUSREQ,
           HTRANS, HADDR, HWRITE, HWDATA, owner
  );
endinterface

// File: rtl/mahbe_master_arb.sv
// Two-channel AHB master arbiter sharing one system master port between TX (M0) and RX (M1) DMA.
// Optional macro MAHBE_ARB_RR_EN: round-robin ties and symmetric hold-based hand-over.
module mahbe_master_arb #(
  parameter int unsigned HOLD_MAX = 16
) (
  input logic                 HCLK,
  input logic                 HRESETn,
  mahbe_master_arb_if.master  bus
);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  localparam logic [7:0] HOLD_LIM  = 8'(HOLD_MAX);

  typedef enum logic [1:0] {PARK = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [7:0]  hold_cnt_reg;
  logic        a_own_reg;
  logic        a_val_reg;
  logic        d_own_reg;
  logic        d_val_reg;

  logic [1:0]  req;
  logic [1:0]  locked;
  logic [1:0]  ch_htrans [2];
  logic        hold_full;
  logic        hand_0;
  logic        hand_1;
  logic        tie_to_g1;
  logic        other_req;
  logic [1:0]  htrans_out;

  assign req          = {bus.m1_hbusreq, bus.m0_hbusreq};
  assign ch_htrans[0] = bus.m0_htrans;
  assign ch_htrans[1] = bus.m1_htrans;

  // A channel in the middle of a burst (SEQ/BUSY) must keep the bus.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    assign locked[gi] = (ch_htrans[gi] == HT_SEQ) || (ch_htrans[gi] == HT_BUSY);
  end

  assign hold_full = (hold_cnt_reg == HOLD_LIM);
  assign hand_1    = hold_full && req[0];
  assign other_req = (state_reg == G0) ? req[1] : req[0];

`ifdef MAHBE_ARB_RR_EN
  logic last_reg;
  assign hand_0    = hold_full && req[1];
  assign tie_to_g1 = !last_reg;
`else
  assign hand_0    = req[1];
  assign tie_to_g1 = 1'b1;
`endif

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      PARK: begin
        if (req[0] && req[1]) state_next = tie_to_g1 ? G1 : G0;
        else if (req[1])      state_next = G1;
        else if (req[0])      state_next = G0;
      end
      G0: begin
        if (!req[0])                   state_next = req[1] ? G1 : PARK;
        else if (hand_0 && !locked[0]) state_next = G1;
      end
      G1: begin
        if (!req[1])                   state_next = req[0] ? G0 : PARK;
        else if (hand_1 && !locked[1]) state_next = G0;
      end
      default: state_next = PARK;
    endcase
  end

  assign htrans_out = a_val_reg ? (a_own_reg ? bus.m1_htrans : bus.m0_htrans) : HT_IDLE;

  // Every register is frozen while the system slave inserts wait states.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg    <= PARK;
      hold_cnt_reg <= '0;
      a_own_reg    <= 1'b0;
      a_val_reg    <= 1'b0;
      d_own_reg    <= 1'b0;
      d_val_reg    <= 1'b0;
`ifdef MAHBE_ARB_RR_EN
      last_reg     <= 1'b1;
`endif
    end else if (bus.HREADY) begin
      a_own_reg <= (state_reg == G1);
      a_val_reg <= (state_reg != PARK) && bus.HGRANT;
      d_own_reg <= a_own_reg;
      d_val_reg <= a_val_reg && ((htrans_out == HT_NONSEQ) || (htrans_out == HT_SEQ));
      if (state_next != state_reg) begin
        state_reg    <= state_next;
        hold_cnt_reg <= '0;
`ifdef MAHBE_ARB_RR_EN
        if (state_next != PARK) last_reg <= (state_next == G1);
`endif
      end else if ((state_reg != PARK) && other_req && !hold_full) begin
        hold_cnt_reg <= hold_cnt_reg + 8'd1;
      end
    end
  end

  assign bus.HBUSREQ   = req[0] | req[1];
  assign bus.m0_hgrant = (state_reg == G0) && bus.HGRANT;
  assign bus.m1_hgrant = (state_reg == G1) && bus.HGRANT;
  assign bus.HTRANS    = htrans_out;
  assign bus.HADDR     = a_own_reg ? bus.m1_haddr  : bus.m0_haddr;
  assign bus.HWRITE    = a_own_reg ? bus.m1_hwrite : bus.m0_hwrite;
  assign bus.HWDATA    = d_val_reg ? (d_own_reg ? bus.m1_hwdata : bus.m0_hwdata) : 32'd0;
  assign bus.owner     = {d_val_reg, d_own_reg};
  assign bus.m_hready  = bus.HREADY;
  assign bus.m_hresp   = bus.HRESP;
  assign bus.m_hrdata  = bus.HRDATA;

endmodule

// File: doc/mahbe_master_arb.md
# mahbe_master_arb

Two-requester AHB master arbiter that shares one system AHB master port between the TX and RX DMA master channels of the MAC AHB engine. It sits between the dual DMA masters and the system bus, merging their bus requests into one HBUSREQ and forwarding the system HGRANT to one channel at a time. It tracks address-phase and data-phase ownership so that address/control and write data are muxed correctly across pipelined transfers. Grant changes only at AHB-legal points.

## Interface
- HOLD_MAX, 16: HREADY-high beats a grant is held while the other channel waits before forced hand-over (range 1..255).
- HCLK  in  1  bus clock; all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- m0_hbusreq / m1_hbusreq  in  1  channel bus request (M0 = TX DMA, M1 = RX DMA).
- m0_htrans / m1_htrans  in  2  channel HTRANS.
- m0_haddr / m1_haddr  in  30  channel HADDR[31:2].
- m0_hwrite / m1_hwrite  in  1  channel HWRITE.
- m0_hwdata / m1_hwdata  in  32  channel HWDATA.
- m0_hgrant / m1_hgrant  out  1  channel grant.
- m_hready  out  1  HREADY broadcast to both channels.
- m_hresp  out  2  HRESP broadcast.
- m_hrdata  out  32  HRDATA broadcast.
- HBUSREQ  out  1  system bus request.
- HGRANT  in  1  system grant.
- HTRANS  out  2; HADDR  out  30 ([31:2]); HWRITE  out  1; HWDATA  out  32: system master outputs.
- HREADY  in  1; HRESP  in  2; HRDATA  in  32: system slave response.
- owner  out  2  {valid, channel} of current data phase, status only.

## Operation
- HBUSREQ = m0_hbusreq | m1_hbusreq (combinational).
- State register: PARK, G0, G1. Reset value PARK. Updates only in cycles with HREADY=1. HREADY=0 freezes all registers.
- mX_hgrant = (state==GX) & HGRANT.
- PARK: only M0 requests -> G0. Only M1 requests -> G1. Both request -> G1 (fixed) or per round-robin (see Configuration). Neither -> PARK.
- GX, own hbusreq=0: go to the other channel's state if it requests, else PARK.
- GX, own hbusreq=1, hand-over condition true, and own htrans is not SEQ or BUSY: go to the other channel's state.
- Hand-over condition in G1: hold_cnt==HOLD_MAX and m0_hbusreq.
- Hand-over condition in G0: m1_hbusreq, immediately; HOLD_MAX is not consulted.
- Grant never changes while the owner drives SEQ or BUSY, so bursts are never split.
- hold_cnt: 8 bits. Reset 0. Cleared on any state change. Increments on HREADY=1 cycles while in GX and the other channel requests. Saturates at HOLD_MAX.
- Address stage, updated when HREADY=1:
  - a_own <= channel of state.
  - a_val <= (state!=PARK) & HGRANT.
- Data stage, updated when HREADY=1:
  - d_own <= a_own.
  - d_val <= a_val & (HTRANS is NONSEQ or SEQ).
- HTRANS = a_val ? m{a_own}_htrans : IDLE.
- HADDR and HWRITE are selected by a_own.
- HWDATA is selected by d_own. It is 0 when d_val=0.
- m_hready = HREADY, m_hresp = HRESP, m_hrdata = HRDATA (pass-through).
- Reset values: state=PARK, a_own=0, a_val=0, d_own=0, d_val=0, hold_cnt=0, last=1.
- Outputs under reset: HTRANS=IDLE, HADDR=m0_haddr, HWDATA=0, grants 0, owner=0.
- Reset asserted mid-transfer clears everything immediately. The in-flight transfer is abandoned; HTRANS=IDLE on the first cycle after reset.

## Timing
- Request seen in cycle N (HREADY=1, PARK, HGRANT=1) -> mX_hgrant=1 in N+1.
- The channel drives NONSEQ in N+2, which appears on HTRANS in N+2.
- Write data for that transfer is muxed in N+3 (zero-wait).
- Hand-over G0->G1: m0_hgrant falls and m1_hgrant rises in the same cycle.
- M0's final data phase completes one cycle later, with HWDATA still from M0 (d_own lag).
- HGRANT deasserted externally: grants drop combinationally in the same cycle, and a_val=0 from the next HREADY edge. The state does not change.
- Wait states: with HREADY=0 for k cycles, all outputs hold their values for those k cycles.

## Configuration
- MAHBE_ARB_RR_EN defined:
  - A 1-bit register `last` records the most recent granted channel.
  - PARK ties go to the channel other than `last`.
  - In G0, the hand-over condition becomes hold_cnt==HOLD_MAX and m1_hbusreq, symmetric with G1.
- MAHBE_ARB_RR_EN undefined: fixed priority M1 over M0 as described in Operation. `last` is not implemented.

## Test plan
- Single channel: M0 requests at cycle 2 with HGRANT=1 and zero-wait, issuing 4-beat write INCR4 at 0x100. Response: m0_hgrant=1 at cycle 3; HTRANS NONSEQ,SEQ,SEQ,SEQ with HADDR 0x40..0x43 ([31:2]); HWDATA matches M0 with a 1-cycle lag; M1 is never granted.
- Fixed priority: both request in PARK. Response: G1 first. M0 requesting during an M1 burst is granted only after HOLD_MAX=16 beats and at an M1 NONSEQ/IDLE boundary. M1 requesting during M0 traffic takes over at M0's next non-SEQ beat.
- Round-robin (MAHBE_ARB_RR_EN): both channels request continuously with single transfers. Response: grants alternate every HOLD_MAX=4 beats; M0 is served first after reset.
- Wait states: HREADY=0 for 3 cycles in mid-burst with a hand-over pending. Response: state, HTRANS, HADDR and HWDATA are frozen; the grant switch occurs only on the first HREADY=1 cycle.
- HGRANT removed during G1. Response: m1_hgrant=0 in the same cycle; HTRANS=IDLE from the next cycle; HGRANT reasserted -> M1 resumes with no state change.
- Reset during an M0 SEQ beat with a pending write. Response: immediately HTRANS=IDLE, HWDATA=0, both grants 0, state PARK; after release, a new request follows standard N+1 grant latency.
